keypad_digit_display: RTL and testbench
=======================================

Name: keypad_digit_display

Overview:
- Downstream consumer of the keypad row-scan FSM.
- Takes the debounced one-hot row, the synchronized column and the single-cycle key-confirm pulse, and decodes them into a hex key code.
- Shifts each new code into a two-digit history (older, newer).
- Time-multiplexes both digits onto the shared dual seven-segment display, with a blanking gap between digit switches.

Parameters:
- CLK_HZ, 48_000_000, system clock frequency; documentation only, not used in logic.
- MUX_DIV, 24_000, clk cycles each digit is driven (500 us at 48 MHz).
- BLANK_CYC, 480, clk cycles both anodes are off between digits (10 us; anti-ghosting).

Ports:
- clk  in  1  48 MHz system clock
- reset  in  1  asynchronous, active-low reset
- row  in  4  one-hot row currently driven by the scanner (row[0] = top row)
- col  in  4  synchronized column sense, active-high (col[0] = leftmost column)
- en  in  1  single-cycle pulse: row/col identify a debounced keypress
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  2  anode enables, active-low; an[1] = left (older digit), an[0] = right (newer digit)
- keyCode  out  4  most recently accepted key
- keyValid  out  1  one-cycle pulse when a key is accepted

Behaviour:
- Key map (row, col 0..3): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E 0 F D.
- Accept condition: en=1, row exactly one-hot, col exactly one-hot.
  - On the clk edge where the condition holds: older <= newer, newer <= decoded code, vld_old <= vld_new, vld_new <= 1.
  - keyCode <= decoded code; keyValid = 1 for exactly the next cycle. Latency from en is 1 cycle.
- en with row or col not one-hot (zero or multiple bits): ignored. No shift, no keyValid, history unchanged.
- en with no accept: keyValid stays 0. Back-to-back en pulses are each accepted independently.
- A digit whose valid flag is 0 displays blank (seg = 7'b1111111).
- Mux FSM states: SHOW_R -> BLANK_R -> SHOW_L -> BLANK_L -> SHOW_R.
  - SHOW_R: an = 2'b10, seg = encode(newer). Lasts MUX_DIV cycles.
  - BLANK_R and BLANK_L: an = 2'b11, seg = 7'b1111111. Each lasts BLANK_CYC cycles.
  - SHOW_L: an = 2'b01, seg = encode(older). Lasts MUX_DIV cycles.
  - One down-counter, reloaded on each state entry; the state advances when the counter reaches 0.
  - Counter width is $clog2(MUX_DIV).
- seg is combinational from the current state and digit registers, so a history update appears on the very next cycle while the corresponding digit is shown. The mux timing is never reset or stalled by key activity.
- Encoding (active-low), for example:
  - 0 = 1000000, 1 = 1111001, 8 = 0000000
  - A = 0001000, b = 0000011, C = 1000110
  - d = 0100001, E = 0000110, F = 0001110
- Reset (asynchronous assert, synchronous release with the clock):
  - state = SHOW_R, counter = MUX_DIV-1
  - older = newer = 0, vld_old = vld_new = 0
  - keyCode = 0, keyValid = 0
  - Result: an = 2'b10, seg = 7'b1111111.
- Reset mid-operation: history is lost, display is blank, mux restarts at SHOW_R. An en coincident with reset assertion is dropped.

Decomposition:
- Shared package keypad_pkg:
  - the 4x4 key-map constant array (row, col -> 4-bit code)
  - mux state enum typedef
  - SEG_BLANK constant
- One sub-module: seven_seg_hex (combinational, 4-bit hex in -> 7-bit active-low seg out).
  - Instantiated once.
  - Top-level selects its input between older and newer.

Test Plan:
- Reset held low 5 cycles, then released -> an=10, seg=1111111, keyValid=0. The first SHOW_R -> BLANK_R transition occurs exactly MUX_DIV cycles after release.
- row=0001, col=0010, en pulse -> next cycle keyValid=1, keyCode=2. During SHOW_R seg=0100100 (the encoding of 2); during SHOW_L seg=1111111.
- Sequence keys "5" (r1,c1) then "D" (r3,c3) -> keyCode=D. SHOW_L seg=0010010 (the encoding of 5); SHOW_R seg=0100001 (the encoding of d). Check through both BLANK gaps (an=11).
- en with col=0110 (two bits), then en with row=0000 -> no keyValid; history unchanged.
- en pulses on two consecutive cycles (keys 1 then 0) -> two keyValid pulses; final older=1, newer=0.
- Assert reset during SHOW_L with history "AB" -> an immediately 10, seg=1111111, history cleared. A subsequent key shows only on the right digit.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : key map, display mux states and shared helpers
// Rev 1.0
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SHOW_R  = 2'd0,
    BLANK_R = 2'd1,
    SHOW_L  = 2'd2,
    BLANK_L = 2'd3
  } mux_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode patterns, active-low: an[1] = left (older), an[0] = right (newer)
  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  // KEY_MAP[row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful when v is one-hot
  function automatic logic [1:0] onehot_idx4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_digit_display_seg.sv
`default_nettype none
// ============================================================================
// seven_seg_hex : 4-bit hex to active-low {g,f,e,d,c,b,a} segment pattern
// Rev 1.0
// ============================================================================
module seven_seg_hex
  import keypad_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/keypad_digit_display.sv
`default_nettype none
// ============================================================================
// keypad_digit_display : decodes confirmed keypresses into a two-digit history
// and time-multiplexes it onto a dual seven-segment display.
// Rev 1.0
// ============================================================================
module keypad_digit_display
  import keypad_pkg::*;
#(
  parameter int CLK_HZ    = 48_000_000,
  parameter int MUX_DIV   = 24_000,
  parameter int BLANK_CYC = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic       en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] keyCode,
  output logic       keyValid
);

  localparam int CNT_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_RELOAD  = CNT_W'(MUX_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYC - 1);

  // The shared down-counter is sized for the show phase; blank must fit in it.
  if (BLANK_CYC > MUX_DIV || CLK_HZ < 1) begin : g_param_out_of_range
  end

  mux_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       an_q;

  logic [3:0] older_q, newer_q;
  logic       vld_old_q, vld_new_q;
  logic [3:0] keycode_q;
  logic       keyvalid_q;

  logic       accept_d;
  logic [3:0] code_d;
  logic [3:0] hex_sel;
  logic [6:0] hex_seg;

  assign accept_d = en && is_onehot4(row) && is_onehot4(col);
  assign code_d   = KEY_MAP[onehot_idx4(row)][onehot_idx4(col)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      older_q    <= 4'd0;
      newer_q    <= 4'd0;
      vld_old_q  <= 1'b0;
      vld_new_q  <= 1'b0;
      keycode_q  <= 4'd0;
      keyvalid_q <= 1'b0;
    end else begin
      keyvalid_q <= accept_d;
      if (accept_d) begin
        older_q   <= newer_q;
        newer_q   <= code_d;
        vld_old_q <= vld_new_q;
        vld_new_q <= 1'b1;
        keycode_q <= code_d;
      end
    end
  end

  // Mux timing free-runs; key activity never touches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW_R;
      cnt_q   <= SHOW_RELOAD;
      an_q    <= AN_RIGHT;
    end else if (cnt_q == '0) begin
      case (state_q)
        SHOW_R: begin
          state_q <= BLANK_R;
          cnt_q   <= BLANK_RELOAD;
          an_q    <= AN_OFF;
        end
        BLANK_R: begin
          state_q <= SHOW_L;
          cnt_q   <= SHOW_RELOAD;
          an_q    <= AN_LEFT;
        end
        SHOW_L: begin
          state_q <= BLANK_L;
          cnt_q   <= BLANK_RELOAD;
          an_q    <= AN_OFF;
        end
        default: begin
          state_q <= SHOW_R;
          cnt_q   <= SHOW_RELOAD;
          an_q    <= AN_RIGHT;
        end
      endcase
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign hex_sel = (state_q == SHOW_L) ? older_q : newer_q;

  seven_seg_hex u_seg (
    .hex_i (hex_sel),
    .seg_o (hex_seg)
  );

  always_comb begin
    seg = SEG_BLANK;
    case (state_q)
      SHOW_R:  if (vld_new_q) seg = hex_seg;
      SHOW_L:  if (vld_old_q) seg = hex_seg;
      default: seg = SEG_BLANK;
    endcase
  end

  assign an       = an_q;
  assign keyCode  = keycode_q;
  assign keyValid = keyvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_display.sv
`default_nettype none
// ============================================================================
// tb_keypad_digit_display : scoreboard bench for keypad_digit_display
// Rev 1.0
// ============================================================================
module tb_keypad_digit_display;

  localparam int MUX_DIV   = 16;
  localparam int BLANK_CYC = 4;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_D = 7'b0100001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row = 4'd0;
  logic [3:0] col = 4'd0;
  logic       en = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] keyCode;
  logic       keyValid;

  typedef struct {
    logic [3:0] code;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  keypad_digit_display #(
    .CLK_HZ    (48_000_000),
    .MUX_DIV   (MUX_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .en       (en),
    .seg      (seg),
    .an       (an),
    .keyCode  (keyCode),
    .keyValid (keyValid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every keyValid pulse must match the oldest outstanding expected key.
  always @(posedge clk) begin
    #1;
    if (keyValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("kv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("kv_code", 32'(keyCode), 32'(mon_e.code));
        chk("kv_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code);
    exp_t e;
    row = r;
    col = c;
    en  = 1'b1;
    e.code = code;
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    en  = 1'b0;
    row = 4'd0;
    col = 4'd0;
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code);
    drive_key(r, c, code);
    tick();
    idle();
  endtask

  task automatic wait_an(input logic [1:0] target, input string tag);
    int n;
    n = 0;
    while (an !== target && n < 200) begin
      tick();
      n++;
    end
    if (an !== target) chk({tag, "_timeout"}, 32'(an), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and first mux transition timing
    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    chk("rst_an", 32'(an), 32'(2'b10));
    chk("rst_seg", 32'(seg), 32'(S_BLANK));
    chk("rst_kv", 32'(keyValid), 32'd0);
    chk("rst_code", 32'(keyCode), 32'd0);
    for (int k = 1; k <= MUX_DIV; k++) begin
      tick();
      if (k == MUX_DIV - 1) chk("showr_last", 32'(an), 32'(2'b10));
      if (k == MUX_DIV)     chk("blankr_first", 32'(an), 32'(2'b11));
    end
    chk("blankr_seg", 32'(seg), 32'(S_BLANK));

    // Single key "2"
    press(4'b0001, 4'b0010, 4'h2);
    wait_an(2'b10, "k2_r");
    chk("k2_right", 32'(seg), 32'(S_2));
    wait_an(2'b01, "k2_l");
    chk("k2_left_blank", 32'(seg), 32'(S_BLANK));

    // "5" then "D", checked through both blanking gaps
    press(4'b0010, 4'b0010, 4'h5);
    tick();
    press(4'b1000, 4'b1000, 4'hD);
    chk("kd_code", 32'(keyCode), 32'hD);
    wait_an(2'b11, "k5d_gap1");
    chk("k5d_gap1_seg", 32'(seg), 32'(S_BLANK));
    wait_an(2'b01, "k5d_l");
    chk("k5d_left", 32'(seg), 32'(S_5));
    wait_an(2'b11, "k5d_gap2");
    chk("k5d_gap2_seg", 32'(seg), 32'(S_BLANK));
    wait_an(2'b10, "k5d_r");
    chk("k5d_right", 32'(seg), 32'(S_D));

    // Non-one-hot row/col must be ignored
    row = 4'b0001; col = 4'b0110; en = 1'b1;
    tick();
    row = 4'b0000; col = 4'b0001; en = 1'b1;
    tick();
    idle();
    repeat (2) tick();
    chk("rej_code", 32'(keyCode), 32'hD);
    wait_an(2'b01, "rej_l");
    chk("rej_left", 32'(seg), 32'(S_5));
    wait_an(2'b10, "rej_r");
    chk("rej_right", 32'(seg), 32'(S_D));

    // Back-to-back keys "1" then "0"
    drive_key(4'b0001, 4'b0001, 4'h1);
    tick();
    drive_key(4'b1000, 4'b0010, 4'h0);
    tick();
    idle();
    tick();
    wait_an(2'b01, "b2b_l");
    chk("b2b_left", 32'(seg), 32'(S_1));
    wait_an(2'b10, "b2b_r");
    chk("b2b_right", 32'(seg), 32'(S_0));

    // History "AB", then reset asserted mid SHOW_L
    press(4'b0001, 4'b1000, 4'hA);
    press(4'b0010, 4'b1000, 4'hB);
    wait_an(2'b01, "ab_l");
    tick();
    chk("ab_left", 32'(seg), 32'(S_A));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'(2'b10));
    chk("mid_rst_seg", 32'(seg), 32'(S_BLANK));
    chk("mid_rst_kv", 32'(keyValid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("post_rst_code", 32'(keyCode), 32'd0);
    press(4'b0001, 4'b0100, 4'h3);
    wait_an(2'b10, "k3_r");
    chk("k3_right", 32'(seg), 32'(S_3));
    wait_an(2'b01, "k3_l");
    chk("k3_left_blank", 32'(seg), 32'(S_BLANK));

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
